// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl - successive-approximation ADC sequencer.
//
// Drives the analog SAR front end (sampling switch, capacitive DAC and
// latched comparator) and returns the converted code with a done pulse.
//
// Optional feature macro: SAR_ADC_AVG4_EN
//   defined   : every accepted start runs 4 back-to-back conversions. The
//               codes are summed in a BITS+2 bit accumulator and
//               result = sum >> 2. done pulses only after the 4th one.
//   undefined : one conversion per accepted start. No accumulator exists.
//
// Handshake: start is a level request with no ready. It is sampled only in
// IDLE together with ena, and one conversion (or group) runs per acceptance.
// Requests seen outside IDLE are dropped, not queued. done is a one-cycle
// qualifier for result. The comparator returns cmp_in one cycle after
// cmp_strobe, and cmp_in is consumed only in DECIDE.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   ena         enable; low in any busy state aborts to IDLE
//   start       conversion request (level sampled in IDLE)
//   cont        restart immediately after DONE
//   cmp_in      comparator decision, 1 = Vin >= Vdac
//   sample_en   sampling switch control
//   dac_code    trial code to the capacitive DAC
//   cmp_strobe  one-cycle comparator latch pulse
//   busy        high in every state except IDLE
//   done        one-cycle pulse when result updates
//   result      last completed code, held until the next done
//   dbg_state   current FSM state, for observation
module sar_adc_ctrl #(
  parameter int BITS          = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            start,
  input  logic            cont,
  input  logic            cmp_in,
  output logic            sample_en,
  output logic [BITS-1:0] dac_code,
  output logic            cmp_strobe,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] result,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_SETTLE = 3'd2,
    S_STROBE = 3'd3,
    S_DECIDE = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam int MAXC  = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int IDX_W = (BITS > 1) ? $clog2(BITS) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BITS-1:0]    code_q, code_d;
  logic [BITS-1:0]    result_q, result_d;
  logic [BITS-1:0]    final_code;
  logic               last_conv;

`ifdef SAR_ADC_AVG4_EN
  logic [BITS+1:0]    acc_q, acc_d;
  logic [1:0]         avg_q, avg_d;
  assign last_conv = (avg_q == 2'd3);
`else
  assign last_conv = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    code_d   = code_q;
    result_d = result_q;
`ifdef SAR_ADC_AVG4_EN
    acc_d    = acc_q;
    avg_d    = avg_q;
`endif
    // Trial code with the current bit resolved by the comparator.
    final_code = code_q;
    if (!cmp_in) final_code[idx_q] = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && ena) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
          code_d  = '0;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          idx_d   = IDX_W'(BITS - 1);
          code_d  = '0;
          code_d[BITS-1] = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STROBE: begin
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (idx_q != '0) begin
          code_d = final_code;
          code_d[idx_q - IDX_W'(1)] = 1'b1;
          idx_d   = idx_q - IDX_W'(1);
          state_d = S_SETTLE;
        end else begin
          // result is loaded on entry to DONE so it lines up with done.
          state_d = S_DONE;
          code_d  = '0;
`ifdef SAR_ADC_AVG4_EN
          acc_d = acc_q + {2'b00, final_code};
          if (avg_q == 2'd3) result_d = acc_d[BITS+1:2];
`else
          result_d = final_code;
`endif
        end
      end
      S_DONE: begin
`ifdef SAR_ADC_AVG4_EN
        if (avg_q != 2'd3) begin
          // Intermediate conversion of a group: no done, go straight on.
          avg_d   = avg_q + 2'd1;
          state_d = S_SAMPLE;
        end else begin
          avg_d   = '0;
          acc_d   = '0;
          state_d = cont ? S_SAMPLE : S_IDLE;
        end
`else
        state_d = cont ? S_SAMPLE : S_IDLE;
`endif
        cnt_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        code_d  = '0;
      end
    endcase

    // Abort wins over everything; result keeps the last completed value.
    if ((state_q != S_IDLE) && !ena) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      idx_d    = '0;
      code_d   = '0;
      result_d = result_q;
`ifdef SAR_ADC_AVG4_EN
      acc_d    = '0;
      avg_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      code_q   <= '0;
      result_q <= '0;
`ifdef SAR_ADC_AVG4_EN
      acc_q    <= '0;
      avg_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      result_q <= result_d;
`ifdef SAR_ADC_AVG4_EN
      acc_q    <= acc_d;
      avg_q    <= avg_d;
`endif
    end
  end

  assign sample_en  = (state_q == S_SAMPLE);
  assign cmp_strobe = (state_q == S_STROBE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE) && last_conv;
  assign dac_code   = code_q;
  assign result     = result_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl - directed bench for sar_adc_ctrl with default parameters.
// A behavioural comparator registers (vin >= dac_code) on cmp_strobe.
// Cycle numbering: cycle 1 is the cycle following the start-accepting edge.
// The SAR_ADC_AVG4_EN build runs the averaging sequence instead of the
// single-conversion sequence.
module tb_sar_adc_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       cont;
  logic       cmp_in;
  logic       sample_en;
  logic [7:0] dac_code;
  logic       cmp_strobe;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [2:0] dbg_state;

  logic [7:0] vin;
  logic [7:0] trial_q[$];
  int         tests;
  int         fails;

  sar_adc_ctrl #(.BITS(8), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .cont       (cont),
    .cmp_in     (cmp_in),
    .sample_en  (sample_en),
    .dac_code   (dac_code),
    .cmp_strobe (cmp_strobe),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // comparator model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmp_in <= 1'b0;
    else if (cmp_strobe) cmp_in <= (vin >= dac_code);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // driver / check tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Request a conversion; returns at the sampling point of cycle 1.
  task automatic start_conv(input logic [7:0] v);
    vin   = v;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called at cycle 1; returns at the cycle where done is high, or past limit.
  task automatic wait_done(output int cyc, output int strobes, output int busy_low);
    cyc = 1; strobes = 0; busy_low = 0;
    while (cyc <= 200) begin
      if (cmp_strobe) begin
        strobes++;
        trial_q.push_back(dac_code);
      end
      if (!busy) busy_low++;
      if (done) break;
      step();
      cyc++;
    end
  endtask

  initial begin
    int cyc, str, bl, dn;
    logic [31:0] exp_t;
    tests = 0; fails = 0;
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; cont = 1'b0; vin = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",      32'(dbg_state),  32'd0);
    chk("rst_sample_en",  32'(sample_en),  32'd0);
    chk("rst_dac_code",   32'(dac_code),   32'd0);
    chk("rst_cmp_strobe", 32'(cmp_strobe), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_result",     32'(result),     32'd0);
    rst_n = 1'b1; ena = 1'b1;
    step();

`ifndef SAR_ADC_AVG4_EN
    // basic conversion
    trial_q.delete();
    start_conv(8'hA5);
    wait_done(cyc, str, bl);
    chk("a5_latency",  32'(cyc),    32'd29);
    chk("a5_result",   32'(result), 32'hA5);
    chk("a5_strobes",  32'(str),    32'd8);
    chk("a5_busy_low", 32'(bl),     32'd0);
    chk("a5_dac_done", 32'(dac_code), 32'd0);
    step();
    chk("a5_done_once", 32'(done),      32'd0);
    chk("a5_idle",      32'(dbg_state), 32'd0);

    // extremes
    start_conv(8'hFF);
    wait_done(cyc, str, bl);
    chk("ff_latency", 32'(cyc),    32'd29);
    chk("ff_result",  32'(result), 32'hFF);
    step();
    trial_q.delete();
    start_conv(8'h00);
    wait_done(cyc, str, bl);
    chk("00_result", 32'(result), 32'h00);
    chk("00_trials", 32'(trial_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < trial_q.size(); k++) begin
      exp_t = 32'h80 >> k;
      chk($sformatf("00_trial%0d", k), 32'(trial_q[k]), exp_t);
    end
    step();

    // continuous mode
    cont = 1'b1;
    start_conv(8'h10);
    wait_done(cyc, str, bl);
    chk("cont1_latency", 32'(cyc),    32'd29);
    chk("cont1_result",  32'(result), 32'h10);
    vin = 8'h20;
    step();
    chk("cont_no_idle",  32'(busy),      32'd1);
    chk("cont_resample", 32'(sample_en), 32'd1);
    cont = 1'b0;
    wait_done(cyc, str, bl);
    chk("cont2_spacing", 32'(cyc),    32'd29);
    chk("cont2_result",  32'(result), 32'h20);
    step();
    chk("cont2_idle", 32'(dbg_state), 32'd0);

    // abort with ena=0 during bit 5
    start_conv(8'h33);
    wait_done(cyc, str, bl);
    chk("pre_abort_result", 32'(result), 32'h33);
    step();
    start_conv(8'h5A);
    repeat (11) step();
    chk("bit5_strobe", 32'(cmp_strobe), 32'd1);
    chk("bit5_trial",  32'(dac_code),   32'h60);
    ena = 1'b0;
    step();
    chk("abort_state",     32'(dbg_state),  32'd0);
    chk("abort_busy",      32'(busy),       32'd0);
    chk("abort_dac",       32'(dac_code),   32'd0);
    chk("abort_sample_en", 32'(sample_en),  32'd0);
    chk("abort_strobe",    32'(cmp_strobe), 32'd0);
    chk("abort_result",    32'(result),     32'h33);
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      if (done) dn++;
      step();
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    ena = 1'b1;

    // reset at the same point
    start_conv(8'h5A);
    repeat (11) step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_result", 32'(result),    32'd0);
    chk("rst_mid_busy",   32'(busy),      32'd0);
    chk("rst_mid_dac",    32'(dac_code),  32'd0);
    chk("rst_mid_state",  32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // start held high through a conversion
    vin   = 8'h3C;
    start = 1'b1;
    step();
    wait_done(cyc, str, bl);
    chk("held_latency", 32'(cyc),    32'd29);
    chk("held_result",  32'(result), 32'h3C);
    step();
    chk("held_idle",    32'(dbg_state), 32'd0);
    chk("held_no_done", 32'(done),      32'd0);
    step();
    chk("held_restart", 32'(sample_en), 32'd1);
    start = 1'b0;
    wait_done(cyc, str, bl);
    chk("held2_result", 32'(result), 32'h3C);
    step();
`else
    // four-conversion average: 0x10+0x11+0x12+0x14 = 0x47, >>2 = 0x11
    begin
      logic [7:0] tbl [4];
      int idx;
      tbl[0] = 8'h10; tbl[1] = 8'h11; tbl[2] = 8'h12; tbl[3] = 8'h14;
      start_conv(8'h10);
      cyc = 1; bl = 0; str = 0;
      while (cyc <= 400) begin
        idx = (cyc - 1) / 29;
        if (idx > 3) idx = 3;
        vin = tbl[idx];
        if (!busy) bl++;
        if (cmp_strobe) str++;
        if (done) break;
        step();
        cyc++;
      end
      chk("avg_latency",  32'(cyc),       32'd116);
      chk("avg_result",   32'(result),    32'h11);
      chk("avg_busy_low", 32'(bl),        32'd0);
      chk("avg_strobes",  32'(str),       32'd32);
      chk("avg_state",    32'(dbg_state), 32'd5);
      step();
      chk("avg_idle",   32'(dbg_state), 32'd0);
      chk("avg_done1",  32'(done),      32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
- Successive-approximation controller that sequences an on-chip analog SAR front end: sample switch, capacitive DAC and latched comparator, all reached through the ua[5:0] analog pins.
- Sits between the digital tile I/O (ui_in/uo_out) and the analog macro.
- Owns all timing of sample, settle, strobe and decide.
- Returns the converted code with a done pulse.

Parameters:
- BITS, 8, resolution; width of dac_code and result.
- SAMPLE_CYCLES, 4, clock cycles sample_en is held high (at least 1).
- SETTLE_CYCLES, 1, DAC settle cycles before each comparator strobe (at least 1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  block enable; 0 aborts to IDLE.
- start  input  1  level-sampled request; one conversion per accepted start.
- cont  input  1  continuous mode: restart immediately after DONE.
- cmp_in  input  1  latched comparator output; 1 means Vin >= Vdac; valid the cycle after cmp_strobe.
- sample_en  output  1  closes the sampling switch.
- dac_code  output  BITS  trial code driving the capacitive DAC.
- cmp_strobe  output  1  one-cycle comparator latch pulse.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when result updates.
- result  output  BITS  last completed conversion; held until the next done.

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, sample_en=0, dac_code=0, cmp_strobe=0, busy=0, done=0, result=0.
  - All counters are cleared.
  - A reset mid-conversion discards the partial result.
- States: IDLE, SAMPLE, SETTLE, STROBE, DECIDE, DONE.
- IDLE:
  - start=1 and ena=1 at an edge -> SAMPLE.
  - start is ignored in every other state (no queueing).
- SAMPLE:
  - sample_en=1 and dac_code=0 for exactly SAMPLE_CYCLES cycles.
  - Then -> SETTLE with bit index i=BITS-1 and dac_code = 1<<(BITS-1).
- SETTLE: held SETTLE_CYCLES cycles, then -> STROBE.
- STROBE: cmp_strobe=1 for one cycle, then -> DECIDE.
- DECIDE: cmp_in is sampled at the end of this cycle.
  - cmp_in=0 clears bit i of the trial code; cmp_in=1 keeps it.
  - If i>0: set bit i-1, decrement i, -> SETTLE.
  - If i=0: -> DONE.
- DONE (one cycle):
  - done=1 and result = final code; result is registered on entry, so it is visible the same cycle as done.
  - dac_code returns to 0.
  - cont=1 and ena=1 -> SAMPLE; otherwise -> IDLE.
- Latency from the start-accepting edge to done high: SAMPLE_CYCLES + BITS*(SETTLE_CYCLES+2) + 1 cycles. With defaults this is 29.
- ena=0 in any non-IDLE state -> IDLE at the next edge.
  - All outputs go to their reset values except result, which is held.
  - done is not pulsed.
- Boundary codes:
  - All-ones input converges to 2^BITS-1.
  - Zero input converges to 0.
  - No arithmetic wrap; only bit set/clear on the trial register.
- cmp_in is sampled only in DECIDE; its value in other states has no effect.

Optional Feature:
- Macro SAR_ADC_AVG4_EN.
- Defined:
  - The block performs 4 back-to-back conversions per accepted start, with no IDLE between them.
  - Results are accumulated in a BITS+2 bit register.
  - result = accumulator >> 2 (truncating).
  - done pulses only after the 4th conversion; latency is 4x the single-conversion latency.
  - ena=0 or reset clears the accumulator and the 2-bit conversion count.
  - cont restarts a new group of 4.
- Undefined:
  - One conversion per start, as above.
  - No accumulator logic exists in the netlist.

Test Plan:
- Bench comparator model: cmp_in := (vin >= dac_code) registered on cmp_strobe.
- Basic conversion: defaults, vin=0xA5, start pulse -> done 29 cycles after the accepting edge, result=0xA5, busy high throughout, exactly 8 cmp_strobe pulses.
- Extremes: vin=0xFF -> result=0xFF; vin=0x00 -> result=0x00. The dac_code trial sequence for 0x00 is 80,40,20,10,08,04,02,01.
- Continuous mode: cont=1, vin stepping 0x10 then 0x20 -> done pulses 29 cycles apart, no IDLE cycle between, results 0x10 then 0x20.
- Abort: ena=0 during bit 5 with result previously 0x33 -> next cycle IDLE, busy=0, dac_code=0, no done pulse, result still 0x33. Asserting rst_n=0 at the same point instead -> result=0 immediately.
- Ignored start: start held high through a conversion with cont=0 -> exactly one done, then a new conversion begins on the edge after returning to IDLE.
- SAR_ADC_AVG4_EN: vin sequence 0x10, 0x11, 0x12, 0x14 -> single done after 116 cycles, result=0x11 (sum 0x47 >> 2).
